rram_instr_fetch: RTL and testbench

- Downstream consumer of the 32-bit instruction memory in the RRAM controller.
- Generates read addresses and read strobes into the instruction memory, then captures the returned word.
- Decodes each word and issues RRAM operations (WRITE/READ/SET/RESET) to the array sequencer over a valid/ready handshake.
- Handles JUMP, NOP and HALT internally; the program counter (PC) lives here.

---
 rtl/rram_ctrl_pkg.sv | 42 ++++
 rtl/rram_instr_decode.sv | 43 ++++
 rtl/rram_instr_fetch.sv | 172 +++++++++++++++++
 tb/tb_rram_instr_fetch.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rram_ctrl_pkg.sv
// Shared definitions for the RRAM controller instruction path: opcodes,
// sequencer op_code encodings, instruction field positions and FSM types.
package rram_ctrl_pkg;

  // Instruction opcodes found in bits [31:28] of each program word
  localparam logic [3:0] OPC_NOP   = 4'h0;
  localparam logic [3:0] OPC_WRITE = 4'h1;
  localparam logic [3:0] OPC_READ  = 4'h2;
  localparam logic [3:0] OPC_SET   = 4'h3;
  localparam logic [3:0] OPC_RESET = 4'h4;
  localparam logic [3:0] OPC_JUMP  = 4'h5;
  localparam logic [3:0] OPC_HALT  = 4'hF;

  // Operation codes presented to the array sequencer
  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_SET   = 2'b10;
  localparam logic [1:0] OP_RESET = 2'b11;

  // Instruction field positions (least significant bit of each field)
  localparam int OPC_LSB    = 28;
  localparam int ADDR_F_LSB = 16;
  localparam int DATA_F_LSB = 0;

  // Fetch/issue controller states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_CAPTURE,
    ST_ISSUE,
    ST_HALTED
  } fetch_state_t;

  // Coarse class of a decoded instruction; illegal opcodes decode as NOP
  typedef enum logic [1:0] {
    KIND_OP,
    KIND_NOP,
    KIND_JUMP,
    KIND_HALT
  } instr_kind_t;

endpackage

// File: rtl/rram_instr_decode.sv
// Combinational instruction decoder: splits a program word into its class,
// sequencer op_code, RRAM address/data fields, jump target and illegal flag.
module rram_instr_decode
  import rram_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 7,
  parameter int OP_ADDR_W  = 12
) (
  input  logic [DATA_WIDTH-1:0] word,
  output instr_kind_t           kind,
  output logic [1:0]            op_code,
  output logic [OP_ADDR_W-1:0]  op_addr,
  output logic [15:0]           op_data,
  output logic [ADDR_WIDTH-1:0] jump_tgt,
  output logic                  illegal
);

  logic [3:0] opcode;

  assign opcode   = word[OPC_LSB +: 4];
  assign op_addr  = word[ADDR_F_LSB +: OP_ADDR_W];
  assign op_data  = word[DATA_F_LSB +: 16];
  assign jump_tgt = word[ADDR_F_LSB +: ADDR_WIDTH];

  // Classify the opcode; anything undefined is flagged and behaves as NOP
  always_comb begin
    kind    = KIND_NOP;
    op_code = OP_WRITE;
    illegal = 1'b0;
    case (opcode)
      OPC_NOP:   kind = KIND_NOP;
      OPC_WRITE: begin kind = KIND_OP; op_code = OP_WRITE; end
      OPC_READ:  begin kind = KIND_OP; op_code = OP_READ;  end
      OPC_SET:   begin kind = KIND_OP; op_code = OP_SET;   end
      OPC_RESET: begin kind = KIND_OP; op_code = OP_RESET; end
      OPC_JUMP:  kind = KIND_JUMP;
      OPC_HALT:  kind = KIND_HALT;
      default:   illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/rram_instr_fetch.sv
// Instruction fetch/issue engine for the RRAM controller. Owns the program
// counter, reads the instruction memory, decodes each word and hands RRAM
// operations to the array sequencer over valid/ready.
// Optional build macro RRAM_IFETCH_PERF_EN adds the retired_cnt output.
module rram_instr_fetch
  import rram_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 7,
  parameter int FETCH_CYCLES = 2,
  parameter int OP_ADDR_W    = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_pc,
  output logic                  imem_rd_cs,
  output logic                  imem_rd_en,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic                  op_valid,
  input  logic                  op_ready,
  output logic [1:0]            op_code,
  output logic [OP_ADDR_W-1:0]  op_addr,
  output logic [15:0]           op_data,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  busy,
  output logic                  halted,
`ifdef RRAM_IFETCH_PERF_EN
  output logic [15:0]           retired_cnt,
`endif
  output logic                  illegal_op
);

  localparam int CNT_W = (FETCH_CYCLES > 1) ? $clog2(FETCH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] FETCH_LAST = CNT_W'(FETCH_CYCLES - 1);

  fetch_state_t          state, state_n;
  logic [CNT_W-1:0]      fetch_cnt;
  logic                  fetch_last;
  logic                  idle_like;
  logic                  accept;

  instr_kind_t           dec_kind;
  logic [1:0]            dec_op_code;
  logic [OP_ADDR_W-1:0]  dec_op_addr;
  logic [15:0]           dec_op_data;
  logic [ADDR_WIDTH-1:0] dec_jump_tgt;
  logic                  dec_illegal;

  rram_instr_decode #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .OP_ADDR_W (OP_ADDR_W)
  ) u_decode (
    .word    (imem_rdata),
    .kind    (dec_kind),
    .op_code (dec_op_code),
    .op_addr (dec_op_addr),
    .op_data (dec_op_data),
    .jump_tgt(dec_jump_tgt),
    .illegal (dec_illegal)
  );

  assign fetch_last = (fetch_cnt == FETCH_LAST);
  assign idle_like  = (state == ST_IDLE) || (state == ST_HALTED);
  assign accept     = (state == ST_ISSUE) && op_valid && op_ready;
  assign imem_addr  = pc;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  // Next-state selection plus the memory strobes, which are only live in FETCH
  always_comb begin
    state_n    = state;
    imem_rd_cs = 1'b0;
    imem_rd_en = 1'b0;
    busy       = 1'b1;
    case (state)
      ST_IDLE, ST_HALTED: begin
        busy = 1'b0;
        if (start) state_n = ST_FETCH;
      end
      ST_FETCH: begin
        imem_rd_cs = 1'b1;
        imem_rd_en = 1'b1;
        if (fetch_last) state_n = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        case (dec_kind)
          KIND_OP:   state_n = ST_ISSUE;
          KIND_HALT: state_n = ST_HALTED;
          default:   state_n = ST_FETCH;
        endcase
      end
      ST_ISSUE: begin
        if (accept) state_n = ST_FETCH;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Program counter, fetch timer, operation registers and status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= '0;
      fetch_cnt  <= '0;
      op_valid   <= 1'b0;
      op_code    <= '0;
      op_addr    <= '0;
      op_data    <= '0;
      halted     <= 1'b0;
      illegal_op <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_HALTED: begin
          if (start) begin
            pc        <= start_pc;
            halted    <= 1'b0;
            fetch_cnt <= '0;
          end
        end
        ST_FETCH: begin
          fetch_cnt <= fetch_last ? '0 : fetch_cnt + CNT_W'(1);
        end
        ST_CAPTURE: begin
          if (dec_illegal) illegal_op <= 1'b1;
          case (dec_kind)
            KIND_OP: begin
              op_valid <= 1'b1;
              op_code  <= dec_op_code;
              op_addr  <= dec_op_addr;
              op_data  <= dec_op_data;
            end
            KIND_JUMP: pc <= dec_jump_tgt;
            KIND_HALT: halted <= 1'b1;
            default:   pc <= pc + ADDR_WIDTH'(1);
          endcase
        end
        ST_ISSUE: begin
          if (accept) begin
            op_valid <= 1'b0;
            pc       <= pc + ADDR_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef RRAM_IFETCH_PERF_EN
  logic retire;

  // An instruction retires on its handshake (ops) or at decode (everything
  // else, illegal words included since they execute as NOP)
  assign retire = accept || ((state == ST_CAPTURE) && (dec_kind != KIND_OP));

  // Saturating retired-instruction counter, restarted with each program run
  always_ff @(posedge clk) begin
    if (rst)
      retired_cnt <= '0;
    else if (idle_like && start)
      retired_cnt <= '0;
    else if (retire && (retired_cnt != 16'hFFFF))
      retired_cnt <= retired_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_rram_instr_fetch.sv
// Self-checking bench for rram_instr_fetch. An instruction-level interpreter
// predicts fetch addresses, issued operations and the final pc/flags; a
// two-stage memory model answers the fetch strobes.
`timescale 1ns/1ps
module tb_rram_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [6:0]  start_pc;
  logic        imem_rd_cs;
  logic        imem_rd_en;
  logic [6:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        op_valid;
  logic        op_ready;
  logic [1:0]  op_code;
  logic [11:0] op_addr;
  logic [15:0] op_data;
  logic [6:0]  pc;
  logic        busy;
  logic        halted;
  logic        illegal_op;
`ifdef RRAM_IFETCH_PERF_EN
  logic [15:0] retired_cnt;
`endif

  rram_instr_fetch dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .start_pc   (start_pc),
    .imem_rd_cs (imem_rd_cs),
    .imem_rd_en (imem_rd_en),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .op_code    (op_code),
    .op_addr    (op_addr),
    .op_data    (op_data),
    .pc         (pc),
    .busy       (busy),
    .halted     (halted),
`ifdef RRAM_IFETCH_PERF_EN
    .retired_cnt(retired_cnt),
`endif
    .illegal_op (illegal_op)
  );

  always #5 clk = ~clk;

  // Instruction memory: pointer registered on the first strobe cycle, data on the next
  logic [31:0] mem [128];
  logic [6:0]  mem_ptr = '0;
  initial imem_rdata = '0;
  always @(posedge clk) begin
    if (imem_rd_cs && imem_rd_en) mem_ptr <= imem_addr;
    imem_rdata <= mem[mem_ptr];
  end

  int vectors = 0;
  int miscompares = 0;

  logic [6:0]  exp_fetch[$], obs_fetch[$];
  logic [29:0] exp_ops[$], obs_ops[$];
  logic [6:0]  exp_pc;
  bit          exp_ill = 1'b0;
  int          valid_cycles;

  // Reference interpreter: walk the program from spc until HALT
  task automatic model(input logic [6:0] spc);
    logic [6:0]  p;
    logic [31:0] w;
    logic [3:0]  code;
    bit          done;
    exp_fetch.delete();
    exp_ops.delete();
    p = spc;
    done = 1'b0;
    for (int s = 0; s < 300 && !done; s++) begin
      exp_fetch.push_back(p);
      w = mem[p];
      code = w[31:28] - 4'd1;
      case (w[31:28])
        4'h0: p = p + 7'd1;
        4'h1, 4'h2, 4'h3, 4'h4: begin
          exp_ops.push_back({code[1:0], w[27:16], w[15:0]});
          p = p + 7'd1;
        end
        4'h5: p = w[22:16];
        4'hF: done = 1'b1;
        default: begin exp_ill = 1'b1; p = p + 7'd1; end
      endcase
    end
    exp_pc = p;
  endtask

  // ready_mode: 0 always ready, 1 random, 2 hold off for the first 10 valid cycles
  task automatic run_program(input logic [6:0] spc, input int ready_mode, input bit poke_start);
    int          run_len;
    logic [6:0]  run_addr;
    bit          prev_pending;
    logic [29:0] prev_fields;
    int          stall_cnt;
    bit          done;
    int          n;
    model(spc);
    obs_fetch.delete();
    obs_ops.delete();
    valid_cycles = 0;
    run_len = 0;
    run_addr = '0;
    prev_pending = 1'b0;
    prev_fields = '0;
    stall_cnt = 0;
    done = 1'b0;
    @(negedge clk);
    op_ready = 1'b0;
    start = 1'b1;
    start_pc = spc;
    @(negedge clk);
    start = 1'b0;
    start_pc = 7'($urandom);
    vectors++;
    if (busy !== 1'b1 || halted !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL start_entry: busy=%b halted=%b, expected busy=1 halted=0", busy, halted);
    end
    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      vectors++;
      if (imem_rd_en !== imem_rd_cs) begin
        miscompares++;
        $display("[TB] FAIL strobe_pair: cs=%b en=%b, expected equal", imem_rd_cs, imem_rd_en);
      end
      if (imem_rd_cs === 1'b1) begin
        if (run_len == 0) begin
          obs_fetch.push_back(imem_addr);
          run_addr = imem_addr;
        end else begin
          vectors++;
          if (imem_addr !== run_addr) begin
            miscompares++;
            $display("[TB] FAIL fetch_addr_hold: addr=%0d, expected %0d", imem_addr, run_addr);
          end
        end
        run_len++;
      end else if (run_len != 0) begin
        vectors++;
        if (run_len != 2) begin
          miscompares++;
          $display("[TB] FAIL fetch_len: strobe run %0d cycles, expected 2", run_len);
        end
        run_len = 0;
      end
      if (prev_pending) begin
        vectors++;
        if (op_valid !== 1'b1 || {op_code, op_addr, op_data} !== prev_fields) begin
          miscompares++;
          $display("[TB] FAIL op_stable: valid=%b fields=%h, expected valid=1 fields=%h",
                   op_valid, {op_code, op_addr, op_data}, prev_fields);
        end
      end
      if (halted === 1'b1 && busy === 1'b0) begin
        done = 1'b1;
      end else begin
        if (op_valid === 1'b1) begin
          valid_cycles++;
          stall_cnt++;
        end
        case (ready_mode)
          0:       op_ready = 1'b1;
          1:       op_ready = 1'($urandom_range(0, 1));
          default: op_ready = (stall_cnt > 10);
        endcase
        start = (poke_start && cyc == 3);
        if (op_valid === 1'b1 && op_ready) obs_ops.push_back({op_code, op_addr, op_data});
        prev_pending = (op_valid === 1'b1) && !op_ready;
        prev_fields = {op_code, op_addr, op_data};
        @(negedge clk);
      end
    end
    start = 1'b0;
    vectors++;
    if (!done) begin
      miscompares++;
      $display("[TB] FAIL halt_timeout: halted=%b busy=%b, expected halted=1 busy=0", halted, busy);
    end
    vectors++;
    if (obs_fetch.size() != exp_fetch.size()) begin
      miscompares++;
      $display("[TB] FAIL fetch_count: %0d fetches, expected %0d", obs_fetch.size(), exp_fetch.size());
    end
    n = (obs_fetch.size() < exp_fetch.size()) ? obs_fetch.size() : exp_fetch.size();
    for (int i = 0; i < n; i++) begin
      vectors++;
      if (obs_fetch[i] !== exp_fetch[i]) begin
        miscompares++;
        $display("[TB] FAIL fetch_seq[%0d]: addr=%0d, expected %0d", i, obs_fetch[i], exp_fetch[i]);
      end
    end
    vectors++;
    if (obs_ops.size() != exp_ops.size()) begin
      miscompares++;
      $display("[TB] FAIL op_count: %0d handshakes, expected %0d", obs_ops.size(), exp_ops.size());
    end
    n = (obs_ops.size() < exp_ops.size()) ? obs_ops.size() : exp_ops.size();
    for (int i = 0; i < n; i++) begin
      vectors++;
      if (obs_ops[i] !== exp_ops[i]) begin
        miscompares++;
        $display("[TB] FAIL op_seq[%0d]: op=%h, expected %h", i, obs_ops[i], exp_ops[i]);
      end
    end
    vectors++;
    if (pc !== exp_pc || illegal_op !== exp_ill) begin
      miscompares++;
      $display("[TB] FAIL final_state: pc=%0d illegal=%b, expected pc=%0d illegal=%b",
               pc, illegal_op, exp_pc, exp_ill);
    end
`ifdef RRAM_IFETCH_PERF_EN
    vectors++;
    if (retired_cnt !== 16'(exp_fetch.size())) begin
      miscompares++;
      $display("[TB] FAIL retired_cnt: %0d, expected %0d", retired_cnt, exp_fetch.size());
    end
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    start_pc = '0;
    op_ready = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({imem_rd_cs, imem_rd_en, imem_addr, op_valid, op_code, op_addr, op_data} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: %h, expected 0",
               {imem_rd_cs, imem_rd_en, imem_addr, op_valid, op_code, op_addr, op_data});
    end
    vectors++;
    if ({pc, busy, halted, illegal_op} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_status: pc=%0d busy=%b halted=%b illegal=%b, expected all 0",
               pc, busy, halted, illegal_op);
    end
`ifdef RRAM_IFETCH_PERF_EN
    vectors++;
    if (retired_cnt !== 16'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_retired: %0d, expected 0", retired_cnt);
    end
`endif
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write_halt();
    mem[0] = 32'h10A5_1234;
    mem[1] = 32'hF000_0000;
    run_program(7'd0, 0, 1'b0);
    vectors++;
    if (obs_ops.size() != 1 || obs_ops[0] !== {2'b00, 12'h0A5, 16'h1234}) begin
      miscompares++;
      $display("[TB] FAIL write_op: count=%0d first=%h, expected 1 x %h",
               obs_ops.size(), (obs_ops.size() > 0) ? obs_ops[0] : 30'h0, {2'b00, 12'h0A5, 16'h1234});
    end
    vectors++;
    if (valid_cycles != 1 || pc !== 7'd1 || halted !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL write_halt_end: valid_cycles=%0d pc=%0d halted=%b busy=%b, expected 1/1/1/0",
               valid_cycles, pc, halted, busy);
    end
  endtask

  task automatic test_stall();
    mem[0] = 32'h3ABC_5A5A;
    mem[1] = 32'hF000_0000;
    run_program(7'd0, 2, 1'b0);
    vectors++;
    if (obs_ops.size() != 1 || valid_cycles != 11 || pc !== 7'd1) begin
      miscompares++;
      $display("[TB] FAIL stall_accept: handshakes=%0d valid_cycles=%0d pc=%0d, expected 1/11/1",
               obs_ops.size(), valid_cycles, pc);
    end
  endtask

  task automatic test_jump();
    mem[5] = 32'h5002_0000;
    mem[2] = 32'h2123_0000;
    mem[3] = 32'hF000_0000;
    run_program(7'd5, 1, 1'b0);
    vectors++;
    if (obs_fetch.size() != 3 || obs_fetch[0] !== 7'd5 || obs_fetch[1] !== 7'd2 || obs_fetch[2] !== 7'd3) begin
      miscompares++;
      $display("[TB] FAIL jump_path: %0d fetches, expected 5,2,3", obs_fetch.size());
    end
    vectors++;
    if (obs_ops.size() != 1 || obs_ops[0][29:28] !== 2'b01 || pc !== 7'd3) begin
      miscompares++;
      $display("[TB] FAIL jump_read: ops=%0d pc=%0d, expected one READ and pc=3", obs_ops.size(), pc);
    end
  endtask

  task automatic test_wrap();
    mem[127] = 32'h0000_0000;
    mem[0]   = 32'hF000_0000;
    run_program(7'd127, 0, 1'b0);
    vectors++;
    if (pc !== 7'd0 || halted !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL pc_wrap: pc=%0d halted=%b, expected pc=0 halted=1", pc, halted);
    end
  endtask

  task automatic test_illegal();
    mem[0] = 32'h9ABC_DEF0;
    mem[1] = 32'hF000_0000;
    run_program(7'd0, 0, 1'b0);
    vectors++;
    if (illegal_op !== 1'b1 || obs_ops.size() != 0 || pc !== 7'd1) begin
      miscompares++;
      $display("[TB] FAIL illegal_first: illegal=%b ops=%0d pc=%0d, expected 1/0/1",
               illegal_op, obs_ops.size(), pc);
    end
    mem[0] = 32'hF000_0000;
    run_program(7'd0, 0, 1'b0);
    vectors++;
    if (illegal_op !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL illegal_sticky: illegal=%b, expected 1", illegal_op);
    end
  endtask

  // Build a random straight-line program with forward-only jumps so it always halts
  task automatic build_program(input logic [6:0] spc, input int len);
    logic [6:0]  a, tgt;
    logic [31:0] w;
    int          sel, fwd;
    for (int i = 0; i < len; i++) begin
      a = spc + 7'(i);
      sel = $urandom_range(0, 7);
      w = $urandom;
      case (sel)
        0:       w[31:28] = 4'h0;
        1, 2:    w[31:28] = 4'($urandom_range(1, 4));
        3, 4:    w[31:28] = 4'($urandom_range(1, 4));
        5: begin
          fwd = $urandom_range(i + 1, len);
          tgt = spc + 7'(fwd);
          w[31:28] = 4'h5;
          w[22:16] = tgt;
        end
        6:       w[31:28] = 4'($urandom_range(6, 14));
        default: w[31:28] = 4'h0;
      endcase
      mem[a] = w;
    end
    a = spc + 7'(len);
    mem[a] = {4'hF, 28'($urandom)};
  endtask

  task automatic test_random();
    logic [6:0] spc;
    for (int t = 0; t < 20; t++) begin
      spc = 7'($urandom);
      build_program(spc, $urandom_range(3, 12));
      run_program(spc, (t % 3 == 0) ? 0 : 1, 1'b0);
    end
  endtask

  task automatic test_start_busy();
    build_program(7'd40, 6);
    run_program(7'd40, 1, 1'b1);
  endtask

  task automatic test_rst_mid();
    bit seen;
    mem[0] = 32'h1123_ABCD;
    mem[1] = 32'hF000_0000;
    seen = 1'b0;
    @(negedge clk);
    op_ready = 1'b0;
    start = 1'b1;
    start_pc = 7'd0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (op_valid === 1'b1) seen = 1'b1;
      else @(negedge clk);
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("[TB] FAIL rst_mid_wait: op_valid=%b, expected 1 within 20 cycles", op_valid);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_ill = 1'b0;
    vectors++;
    if ({op_valid, op_code, op_addr, op_data, pc, busy, halted, illegal_op, imem_rd_cs} !== '0) begin
      miscompares++;
      $display("[TB] FAIL rst_mid: valid=%b pc=%0d busy=%b halted=%b illegal=%b, expected all 0",
               op_valid, pc, busy, halted, illegal_op);
    end
`ifdef RRAM_IFETCH_PERF_EN
    vectors++;
    if (retired_cnt !== 16'd0) begin
      miscompares++;
      $display("[TB] FAIL rst_mid_retired: %0d, expected 0", retired_cnt);
    end
`endif
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || imem_rd_cs !== 1'b0 || op_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL rst_mid_idle: busy=%b cs=%b valid=%b, expected 0/0/0", busy, imem_rd_cs, op_valid);
    end
    run_program(7'd0, 0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'hF000_0000;
    test_reset();
    test_write_halt();
    test_stall();
    test_jump();
    test_wrap();
    test_illegal();
    test_start_busy();
    test_random();
    test_rst_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
